// File: rtl/tap_pkg.sv
// Shared TAP definitions: controller state encoding, register widths and
// the bit-count helper used by the data registers.
package tap_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR_SCAN   = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR_SCAN   = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_e;

    localparam int IR_WIDTH = 5;
    localparam int DR_WIDTH = 32;

    // Shift counter must hold 0..w+1 so over-length scans stay detectable.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/tap_negedge_ff.sv
// Falling-edge register with synchronous active-low reset; used wherever
// the TAP must launch data on the falling edge of TCK (e.g. TDO).
module tap_negedge_ff #(
    parameter int            W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Capture d on the falling edge; reset is sampled on that same edge.
    always_ff @(negedge clk_i) begin
        if (!rst_ni) q_q <= RST_VAL;
        else         q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/tap_dr_reg.sv
// JTAG data register: capture / shift / update with a shift-length check
// guarding the parallel update, and a falling-edge retimed TDO.
module tap_dr_reg
    import tap_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               STRICT_LEN = 1'b1
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             sel_i,
    input  logic             capture_dr_i,
    input  logic             shift_dr_i,
    input  logic             update_dr_i,
    input  logic             tdi_i,
    input  logic [WIDTH-1:0] cap_data_i,
    output logic [WIDTH-1:0] upd_data_o,
    output logic             upd_valid_o,
    output logic             len_err_o,
    output logic             tdo_o
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd_valid_q, upd_valid_d;
    logic             len_err_q, len_err_d;
    logic [WIDTH-1:0] shifted;
    logic             len_ok;

    // LSB leaves first; TDI enters at the MSB.
    if (WIDTH == 1) begin : g_w1
        assign shifted = tdi_i;
    end else begin : g_wn
        assign shifted = {tdi_i, shift_q[WIDTH-1:1]};
    end

    assign len_ok = !STRICT_LEN || (cnt_q == CNT_FULL);

    // Strobe decode: capture beats shift beats update; deselected holds.
    always_comb begin
        shift_d     = shift_q;
        upd_d       = upd_q;
        cnt_d       = cnt_q;
        len_err_d   = len_err_q;
        upd_valid_d = 1'b0;
        if (sel_i) begin
            if (capture_dr_i) begin
                shift_d   = cap_data_i;
                cnt_d     = '0;
                len_err_d = 1'b0;
            end else if (shift_dr_i) begin
                shift_d = shifted;
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end else if (update_dr_i) begin
                if (len_ok) begin
                    upd_d       = shift_q;
                    upd_valid_d = 1'b1;
                end else begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    // Rising-edge state; reset wins over every strobe.
    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            shift_q     <= RESET_VAL;
            upd_q       <= RESET_VAL;
            cnt_q       <= '0;
            upd_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            upd_q       <= upd_d;
            cnt_q       <= cnt_d;
            upd_valid_q <= upd_valid_d;
            len_err_q   <= len_err_d;
        end
    end

    tap_negedge_ff #(.W(1), .RST_VAL(1'b0)) u_tdo_ff (
        .clk_i  (tck_i),
        .rst_ni (trst_ni),
        .d_i    (shift_q[0]),
        .q_o    (tdo_o)
    );

    assign upd_data_o  = upd_q;
    assign upd_valid_o = upd_valid_q;
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_tap_dr_reg.sv
// Bench for tap_dr_reg: an 8-bit strict instance driven from a vector table
// (a relaxed twin checked on selected rows) plus a WIDTH=1 hand sequence.
module tb_tap_dr_reg;

    logic       tck = 1'b0;
    logic       trst_n, sel, cap, sh, upd, tdi;
    logic [7:0] cap_data;

    logic [7:0] d8, d0;
    logic       v8, e8, t8, v0, e0, t0;
    logic       d1, v1, e1, t1;

    int total = 0;
    int passed = 0;

    always #5 tck = ~tck;

    tap_dr_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .STRICT_LEN(1'b1)) dut (
        .tck_i(tck), .trst_ni(trst_n), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi), .cap_data_i(cap_data),
        .upd_data_o(d8), .upd_valid_o(v8), .len_err_o(e8), .tdo_o(t8));

    tap_dr_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .STRICT_LEN(1'b0)) dut0 (
        .tck_i(tck), .trst_ni(trst_n), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi), .cap_data_i(cap_data),
        .upd_data_o(d0), .upd_valid_o(v0), .len_err_o(e0), .tdo_o(t0));

    tap_dr_reg #(.WIDTH(1), .RESET_VAL(1'b0), .STRICT_LEN(1'b1)) dut1 (
        .tck_i(tck), .trst_ni(trst_n), .sel_i(sel), .capture_dr_i(cap),
        .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi), .cap_data_i(cap_data[0]),
        .upd_data_o(d1), .upd_valid_o(v1), .len_err_o(e1), .tdo_o(t1));

    typedef struct {
        logic       rst_n, sel, cap, sh, upd, tdi;
        logic [7:0] cd;
        logic [7:0] ed;
        logic       ev, ee, et;
        logic       c0;
        logic [7:0] e0d;
        logic       e0v, e0e;
    } vec_t;

    vec_t tv[$];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic add(input logic r, s, c, h, u, t, input logic [7:0] cd,
                       input logic [7:0] ed, input logic ev, ee, et);
        vec_t v;
        v.rst_n = r; v.sel = s; v.cap = c; v.sh = h; v.upd = u; v.tdi = t;
        v.cd = cd; v.ed = ed; v.ev = ev; v.ee = ee; v.et = et;
        v.c0 = 1'b0; v.e0d = '0; v.e0v = 1'b0; v.e0e = 1'b0;
        tv.push_back(v);
    endtask

    // Attach relaxed-instance expectations to the most recent row.
    task automatic add0(input logic [7:0] d, input logic v, e);
        tv[tv.size()-1].c0  = 1'b1;
        tv[tv.size()-1].e0d = d;
        tv[tv.size()-1].e0v = v;
        tv[tv.size()-1].e0e = e;
    endtask

    task automatic drive(input logic r, s, c, h, u, t, input logic [7:0] cd);
        trst_n = r; sel = s; cap = c; sh = h; upd = u; tdi = t; cap_data = cd;
    endtask

    // Entered just after a falling edge; returns just after the next one.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        drive(v.rst_n, v.sel, v.cap, v.sh, v.upd, v.tdi, v.cd);
        exp_q.push_back(v);
        @(posedge tck); #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d data", idx),  32'(d8), 32'(e.ed));
        chk($sformatf("v%0d valid", idx), 32'(v8), 32'(e.ev));
        chk($sformatf("v%0d err", idx),   32'(e8), 32'(e.ee));
        if (e.c0) begin
            chk($sformatf("v%0d relaxed data", idx),  32'(d0), 32'(e.e0d));
            chk($sformatf("v%0d relaxed valid", idx), 32'(v0), 32'(e.e0v));
            chk($sformatf("v%0d relaxed err", idx),   32'(e0), 32'(e.e0e));
        end
        @(negedge tck); #1;
        chk($sformatf("v%0d tdo", idx), 32'(t8), 32'(e.et));
    endtask

    task automatic cyc1(input string nm, input logic r, s, c, h, u, t, input logic [7:0] cd,
                        input logic ed, ev, ee, et);
        drive(r, s, c, h, u, t, cd);
        @(posedge tck); #1;
        chk({nm, " data"},  32'(d1), 32'(ed));
        chk({nm, " valid"}, 32'(v1), 32'(ev));
        chk({nm, " err"},   32'(e1), 32'(ee));
        @(negedge tck); #1;
        chk({nm, " tdo"}, 32'(t1), 32'(et));
    endtask

    initial begin
        logic [7:0] s_tdi, s_tdo, s7_tdo, s12_tdo, s4_tdo;
        s_tdi   = 8'b0000_1101;  // 1,0,1,1,0,0,0,0
        s_tdo   = 8'b1001_1110;  // 0,1,1,1,1,0,0,1 after each shift of 8'h3C
        s7_tdo  = 8'b0111_1000;  // 0,0,0,1,1,1,1 shifting ones into 8'hF0
        s12_tdo = 8'b0001_1110;  // 0,1,1,1,1,0,... shifting zeros into 8'h3C
        s4_tdo  = 8'b0000_1110;  // 0,1,1,1 shifting ones into 8'h3C

        drive(0, 0, 0, 0, 0, 0, 8'h00);

        // reset with strobes toggling
        add(0,1,1,0,1,0,8'h00, 8'hA5,0,0,0);
        add(0,1,0,1,1,1,8'hFF, 8'hA5,0,0,0);
        // capture 3C, 8 shifts, update -> 0D single pulse
        add(1,1,1,0,0,0,8'h3C, 8'hA5,0,0,0);
        for (int i = 0; i < 8; i++) add(1,1,0,1,0,s_tdi[i],8'h00, 8'hA5,0,0,s_tdo[i]);
        add(1,1,0,0,1,0,8'h00, 8'h0D,1,0,1);
        add(1,1,0,0,0,0,8'h00, 8'h0D,0,0,1);
        // short scan: 7 shifts -> error, no update
        add(1,1,1,0,0,0,8'hF0, 8'h0D,0,0,0);
        for (int i = 0; i < 7; i++) add(1,1,0,1,0,1,8'h00, 8'h0D,0,0,s7_tdo[i]);
        add(1,1,0,0,1,0,8'h00, 8'h0D,0,1,1);
        // deselected strobes change nothing, error stays sticky
        add(1,0,1,0,0,0,8'h00, 8'h0D,0,1,1);
        add(1,0,0,1,0,0,8'h00, 8'h0D,0,1,1);
        add(1,0,0,0,1,0,8'h00, 8'h0D,0,1,1);
        add(1,0,1,1,1,0,8'h00, 8'h0D,0,1,1);
        // next capture clears the error
        add(1,1,1,0,0,0,8'h3C, 8'h0D,0,0,0);
        // 12 shifts: strict rejects, relaxed commits
        for (int i = 0; i < 12; i++)
            add(1,1,0,1,0,0,8'h00, 8'h0D,0,0,(i < 8) ? s12_tdo[i] : 1'b0);
        add(1,1,0,0,1,0,8'h00, 8'h0D,0,1,0);
        add0(8'h00,1,0);
        add(1,1,0,0,0,0,8'h00, 8'h0D,0,1,0);
        add0(8'h00,0,0);
        // reset mid-shift after 4 bits
        add(1,1,1,0,0,0,8'h3C, 8'h0D,0,0,0);
        for (int i = 0; i < 4; i++) add(1,1,0,1,0,1,8'h00, 8'h0D,0,0,s4_tdo[i]);
        add(0,1,0,1,0,1,8'h00, 8'hA5,0,0,0);
        add0(8'hA5,0,0);
        add(1,1,0,0,0,0,8'h00, 8'hA5,0,0,1);
        // update with no capture since reset is a short scan
        add(1,1,0,0,1,0,8'h00, 8'hA5,0,1,1);
        // full scan after reset succeeds
        add(1,1,1,0,0,0,8'h3C, 8'hA5,0,0,0);
        for (int i = 0; i < 8; i++) add(1,1,0,1,0,s_tdi[i],8'h00, 8'hA5,0,0,s_tdo[i]);
        add(1,1,0,0,1,0,8'h00, 8'h0D,1,0,1);
        add(1,1,0,0,0,0,8'h00, 8'h0D,0,0,1);

        @(negedge tck); #1;
        for (int i = 0; i < tv.size(); i++) apply(i, tv[i]);

        // WIDTH=1: one shift is legal, two shifts is an error
        cyc1("w1 cap",   1,1,1,0,0,0,8'h00, 1'b0,0,0,0);
        cyc1("w1 sh",    1,1,0,1,0,1,8'h00, 1'b0,0,0,1);
        cyc1("w1 upd",   1,1,0,0,1,0,8'h00, 1'b1,1,0,1);
        cyc1("w1 cap2",  1,1,1,0,0,0,8'h00, 1'b1,0,0,0);
        cyc1("w1 sh2a",  1,1,0,1,0,1,8'h00, 1'b1,0,0,1);
        cyc1("w1 sh2b",  1,1,0,1,0,0,8'h00, 1'b1,0,0,0);
        cyc1("w1 upd2",  1,1,0,0,1,0,8'h00, 1'b1,0,1,0);
        cyc1("w1 idle",  1,1,0,0,0,0,8'h00, 1'b1,0,1,0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
